// File: rtl/pc_select_predictor.sv
// pc_select_predictor: fetch PC register with BHT/BTB next-PC prediction and
// execute-stage resolution (redirect, flush, table training).
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   stall               hold the fetch PC (a flush still redirects)
//   pc                  current fetch PC
//   pred_taken          prediction for pc, travels down the pipe with it
//   pred_target         predicted next PC for pc (pc+4 on a BTB miss)
//   ex_valid            execute stage holds a valid instruction
//   ex_opcode           execute-stage opcode
//   ex_pc               execute-stage instruction PC
//   ex_branch_result    branch comparison outcome
//   ex_alu_target       ALU-computed target (bit 0 is ignored)
//   ex_pred_taken       pred_taken as issued with the execute instruction
//   ex_pred_target      pred_target as issued with the execute instruction
//   flush               kill younger instructions this cycle
//   pc_input_sel        PC_INPUT_ALU when the resolved next PC is the ALU target

package pc_select_pkg;

  typedef enum logic [6:0] {
    OPCODE_LOAD     = 7'b0000011,
    OPCODE_MISC_MEM = 7'b0001111,
    OPCODE_OP_IMM   = 7'b0010011,
    OPCODE_AUIPC    = 7'b0010111,
    OPCODE_STORE    = 7'b0100011,
    OPCODE_OP       = 7'b0110011,
    OPCODE_LUI      = 7'b0110111,
    OPCODE_BRANCH   = 7'b1100011,
    OPCODE_JALR     = 7'b1100111,
    OPCODE_JAL      = 7'b1101111,
    OPCODE_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic {
    PC_INPUT_PC_PLUS_4 = 1'b0,
    PC_INPUT_ALU       = 1'b1
  } pc_input_sel_t;

endpackage

module pc_select_predictor
  import pc_select_pkg::*;
#(
  parameter int unsigned       XLEN         = 32,
  parameter int unsigned       ENTRIES      = 64,
  parameter int unsigned       CTR_BITS     = 2,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  output logic [XLEN-1:0]     pc,
  output logic                pred_taken,
  output logic [XLEN-1:0]     pred_target,
  input  logic                ex_valid,
  input  opcode_t             ex_opcode,
  input  logic [XLEN-1:0]     ex_pc,
  input  logic                ex_branch_result,
  input  logic [XLEN-1:0]     ex_alu_target,
  input  logic                ex_pred_taken,
  input  logic [XLEN-1:0]     ex_pred_target,
  output logic                flush,
  output pc_input_sel_t       pc_input_sel
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam int unsigned TAG_BITS = XLEN - IDX_BITS - 2;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  // Weakly-not-taken: all ones shifted right gives 2^(CTR_BITS-1)-1.
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_MAX >> 1;

  logic [CTR_BITS-1:0] ctr        [ENTRIES];
  logic                btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [XLEN-1:0]     btb_target [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic                fetch_hit;
  logic [XLEN-1:0]     pc_plus_4;

  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0] ex_tag;
  logic                is_branch;
  logic                is_jump;
  logic                actual_taken;
  logic [XLEN-1:0]     actual_target;
  logic [XLEN-1:0]     ex_pc_plus_4;
  logic                mispredict;

  // Fetch-side prediction from the registered pc
  always_comb begin
    fetch_idx   = pc[IDX_BITS+1:2];
    fetch_tag   = pc[XLEN-1:IDX_BITS+2];
    pc_plus_4   = pc + XLEN'(4);
    fetch_hit   = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    pred_taken  = fetch_hit && ctr[fetch_idx][CTR_BITS-1];
    pred_target = fetch_hit ? btb_target[fetch_idx] : pc_plus_4;
  end

  // Execute-side resolution
  always_comb begin
    ex_idx        = ex_pc[IDX_BITS+1:2];
    ex_tag        = ex_pc[XLEN-1:IDX_BITS+2];
    ex_pc_plus_4  = ex_pc + XLEN'(4);
    is_branch     = (ex_opcode == OPCODE_BRANCH);
    is_jump       = (ex_opcode == OPCODE_JAL) || (ex_opcode == OPCODE_JALR);
    actual_taken  = ex_valid && ((is_branch && ex_branch_result) || is_jump);
    actual_target = ex_alu_target & ~XLEN'(1);
    mispredict    = (actual_taken != ex_pred_taken) ||
                    (actual_taken && (actual_target != ex_pred_target));
    flush         = ex_valid && mispredict && !reset;
    pc_input_sel  = (actual_taken && !reset) ? PC_INPUT_ALU : PC_INPUT_PC_PLUS_4;
  end

  // Fetch PC: reset > flush > stall > prediction > sequential
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else if (flush) begin
      pc <= actual_taken ? actual_target : ex_pc_plus_4;
    end else if (!stall) begin
      pc <= pred_taken ? pred_target : pc_plus_4;
    end
  end

  // Counters and valid bits carry reset state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr[i]       <= CTR_WEAK;
        btb_valid[i] <= 1'b0;
      end
    end else if (ex_valid) begin
      if (is_branch) begin
        if (actual_taken && (ctr[ex_idx] != CTR_MAX)) begin
          ctr[ex_idx] <= ctr[ex_idx] + CTR_BITS'(1);
        end else if (!actual_taken && (ctr[ex_idx] != '0)) begin
          ctr[ex_idx] <= ctr[ex_idx] - CTR_BITS'(1);
        end
      end else if (is_jump) begin
        ctr[ex_idx] <= CTR_MAX;
      end

      // A non-control instruction that was predicted taken hit an aliased
      // entry; drop it so the same PC stops redirecting.
      if (actual_taken) begin
        btb_valid[ex_idx] <= 1'b1;
      end else if (!is_branch && !is_jump && ex_pred_taken) begin
        btb_valid[ex_idx] <= 1'b0;
      end
    end
  end

  // Tag/target payload is qualified by btb_valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (!reset && actual_taken) begin
      btb_tag[ex_idx]    <= ex_tag;
      btb_target[ex_idx] <= actual_target;
    end
  end

endmodule

// File: tb/tb_pc_select_predictor.sv
// Directed testbench for pc_select_predictor (XLEN=32, ENTRIES=64,
// CTR_BITS=2, RESET_VECTOR=0). Inputs change on the falling edge; outputs are
// checked 1 time unit later, so registered state reflects the previous
// rising edge.

module tb_pc_select_predictor;
  import pc_select_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic [31:0]   pc;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          ex_valid;
  opcode_t       ex_opcode;
  logic [31:0]   ex_pc;
  logic          ex_branch_result;
  logic [31:0]   ex_alu_target;
  logic          ex_pred_taken;
  logic [31:0]   ex_pred_target;
  logic          flush;
  pc_input_sel_t pc_input_sel;

  int tests  = 0;
  int failed = 0;

  pc_select_predictor #(
    .XLEN(32),
    .ENTRIES(64),
    .CTR_BITS(2),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .pc(pc),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .ex_valid(ex_valid),
    .ex_opcode(ex_opcode),
    .ex_pc(ex_pc),
    .ex_branch_result(ex_branch_result),
    .ex_alu_target(ex_alu_target),
    .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .flush(flush),
    .pc_input_sel(pc_input_sel)
  );

  always #5 clk = ~clk;

  task automatic set_ex(input logic v, input opcode_t op, input logic [31:0] epc,
                        input logic res, input logic [31:0] tgt,
                        input logic ptk, input logic [31:0] ptgt);
    ex_valid         = v;
    ex_opcode        = op;
    ex_pc            = epc;
    ex_branch_result = res;
    ex_alu_target    = tgt;
    ex_pred_taken    = ptk;
    ex_pred_target   = ptgt;
  endtask

  task automatic idle_ex();
    set_ex(1'b0, OPCODE_OP, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Advance one cycle with no execute instruction, then let outputs settle
  task automatic next_cycle();
    @(negedge clk);
    idle_ex();
    #1;
  endtask

  // Redirect fetch to t using a falsely-predicted ALU op at t-4
  // (this purges the BTB entry indexed by t-4)
  task automatic steer(input logic [31:0] t);
    set_ex(1'b1, OPCODE_OP, t - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    set_ex(1'b1, OPCODE_BRANCH, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++; if (flush !== 1'b0) begin failed++; $display("FAIL reset_flush: got %b want 0", flush); end
    tests++; if (pc_input_sel !== PC_INPUT_PC_PLUS_4) begin failed++; $display("FAIL reset_sel: got %0d want 0", pc_input_sel); end
    idle_ex();
    reset = 1'b0;
    #1;
    tests++; if (pc !== 32'h0) begin failed++; $display("FAIL reset_pc0: got %h want 00000000", pc); end
    tests++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL reset_pred0: got %b want 0", pred_taken); end
    next_cycle();
    tests++; if (pc !== 32'h4) begin failed++; $display("FAIL reset_pc4: got %h want 00000004", pc); end
    tests++; if (pred_taken !== 1'b0 || flush !== 1'b0) begin failed++; $display("FAIL reset_pred4: got pt=%b fl=%b want 0/0", pred_taken, flush); end
    next_cycle();
    tests++; if (pc !== 32'h8) begin failed++; $display("FAIL reset_pc8: got %h want 00000008", pc); end
    tests++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL reset_pred8: got %b want 0", pred_taken); end
  endtask

  task automatic test_branch_train();
    steer(32'h10);
    tests++; if (pc !== 32'h10) begin failed++; $display("FAIL steer_10: got %h want 00000010", pc); end
    tests++; if (pred_taken !== 1'b0 || pred_target !== 32'h14) begin failed++; $display("FAIL untrained_10: got pt=%b tgt=%h want 0/00000014", pred_taken, pred_target); end
    // Branch at 0x10 resolves taken to 0x40, predicted not-taken
    set_ex(1'b1, OPCODE_BRANCH, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    #1;
    tests++; if (flush !== 1'b1) begin failed++; $display("FAIL br_taken_flush: got %b want 1", flush); end
    tests++; if (pc_input_sel !== PC_INPUT_ALU) begin failed++; $display("FAIL br_taken_sel: got %0d want 1", pc_input_sel); end
    tests++; if (pred_taken !== 1'b0) begin failed++; $display("FAIL same_cycle_pred: got %b want 0", pred_taken); end
    next_cycle();
    tests++; if (pc !== 32'h40) begin failed++; $display("FAIL br_redirect: got %h want 00000040", pc); end
    steer(32'h10);
    tests++; if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin failed++; $display("FAIL trained_10: got pt=%b tgt=%h want 1/00000040", pred_taken, pred_target); end
  endtask

  task automatic test_branch_untrain();
    // Correctly predicted taken: counter 10 -> 11, no flush
    set_ex(1'b1, OPCODE_BRANCH, 32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
    #1;
    tests++; if (flush !== 1'b0 || pc_input_sel !== PC_INPUT_ALU) begin failed++; $display("FAIL br_correct: got fl=%b sel=%0d want 0/1", flush, pc_input_sel); end
    next_cycle();
    tests++; if (pc !== 32'h40) begin failed++; $display("FAIL follow_pred: got %h want 00000040", pc); end
    // First not-taken: counter 11 -> 10, redirect to ex_pc+4
    set_ex(1'b1, OPCODE_BRANCH, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
    #1;
    tests++; if (flush !== 1'b1 || pc_input_sel !== PC_INPUT_PC_PLUS_4) begin failed++; $display("FAIL br_nt1: got fl=%b sel=%0d want 1/0", flush, pc_input_sel); end
    next_cycle();
    tests++; if (pc !== 32'h14) begin failed++; $display("FAIL br_nt1_pc: got %h want 00000014", pc); end
    steer(32'h10);
    tests++; if (pred_taken !== 1'b1) begin failed++; $display("FAIL ctr_10_pred: got %b want 1", pred_taken); end
    // Second not-taken: counter 10 -> 01
    set_ex(1'b1, OPCODE_BRANCH, 32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
    next_cycle();
    tests++; if (pc !== 32'h14) begin failed++; $display("FAIL br_nt2_pc: got %h want 00000014", pc); end
    steer(32'h10);
    tests++; if (pred_taken !== 1'b0 || pred_target !== 32'h40) begin failed++; $display("FAIL ctr_01_pred: got pt=%b tgt=%h want 0/00000040", pred_taken, pred_target); end
  endtask

  task automatic test_jalr();
    set_ex(1'b1, OPCODE_JALR, 32'h20, 1'b0, 32'h81, 1'b0, 32'h24);
    #1;
    tests++; if (flush !== 1'b1 || pc_input_sel !== PC_INPUT_ALU) begin failed++; $display("FAIL jalr_flush: got fl=%b sel=%0d want 1/1", flush, pc_input_sel); end
    next_cycle();
    tests++; if (pc !== 32'h80) begin failed++; $display("FAIL jalr_bit0: got %h want 00000080", pc); end
    steer(32'h20);
    tests++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin failed++; $display("FAIL jalr_btb: got pt=%b tgt=%h want 1/00000080", pred_taken, pred_target); end
    // A not-taken branch at 0x20 leaves the counter at 10 only if it was 11
    set_ex(1'b1, OPCODE_BRANCH, 32'h20, 1'b0, 32'h80, 1'b1, 32'h80);
    next_cycle();
    tests++; if (pc !== 32'h24) begin failed++; $display("FAIL jalr_nt_pc: got %h want 00000024", pc); end
    steer(32'h20);
    tests++; if (pred_taken !== 1'b1) begin failed++; $display("FAIL jalr_ctr_max: got %b want 1", pred_taken); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      tests++; if (pc !== 32'h20) begin failed++; $display("FAIL stall_hold%0d: got %h want 00000020", i, pc); end
    end
    set_ex(1'b1, OPCODE_JAL, 32'h200, 1'b0, 32'h300, 1'b0, 32'h204);
    #1;
    tests++; if (flush !== 1'b1) begin failed++; $display("FAIL stall_flush: got %b want 1", flush); end
    next_cycle();
    tests++; if (pc !== 32'h300) begin failed++; $display("FAIL flush_over_stall: got %h want 00000300", pc); end
    next_cycle();
    tests++; if (pc !== 32'h300) begin failed++; $display("FAIL stall_after_flush: got %h want 00000300", pc); end
    stall = 1'b0;
  endtask

  task automatic test_alias();
    set_ex(1'b1, OPCODE_BRANCH, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    next_cycle();
    tests++; if (pc !== 32'h40) begin failed++; $display("FAIL alias_train: got %h want 00000040", pc); end
    steer(32'h110);
    tests++; if (pred_taken !== 1'b0 || pred_target !== 32'h114) begin failed++; $display("FAIL alias_tag: got pt=%b tgt=%h want 0/00000114", pred_taken, pred_target); end
    // Non-control op not predicted taken: nothing to fix
    set_ex(1'b1, OPCODE_OP, 32'h110, 1'b1, 32'h999, 1'b0, 32'h114);
    #1;
    tests++; if (flush !== 1'b0 || pc_input_sel !== PC_INPUT_PC_PLUS_4) begin failed++; $display("FAIL add_no_flush: got fl=%b sel=%0d want 0/0", flush, pc_input_sel); end
    // ADD predicted taken via alias: flush to ex_pc+4 and purge index 4
    set_ex(1'b1, OPCODE_OP, 32'h110, 1'b0, 32'h0, 1'b1, 32'h40);
    #1;
    tests++; if (flush !== 1'b1 || pc_input_sel !== PC_INPUT_PC_PLUS_4) begin failed++; $display("FAIL alias_flush: got fl=%b sel=%0d want 1/0", flush, pc_input_sel); end
    next_cycle();
    tests++; if (pc !== 32'h114) begin failed++; $display("FAIL alias_pc: got %h want 00000114", pc); end
    steer(32'h10);
    tests++; if (pred_taken !== 1'b0 || pred_target !== 32'h14) begin failed++; $display("FAIL alias_purged: got pt=%b tgt=%h want 0/00000014", pred_taken, pred_target); end
    // ex_valid low: no resolution even with a taken branch on the bus
    set_ex(1'b0, OPCODE_BRANCH, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    #1;
    tests++; if (flush !== 1'b0 || pc_input_sel !== PC_INPUT_PC_PLUS_4) begin failed++; $display("FAIL invalid_ex: got fl=%b sel=%0d want 0/0", flush, pc_input_sel); end
  endtask

  task automatic test_wrap();
    steer(32'hFFFF_FFFC);
    tests++; if (pc !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_steer: got %h want fffffffc", pc); end
    next_cycle();
    tests++; if (pc !== 32'h0) begin failed++; $display("FAIL wrap_pc: got %h want 00000000", pc); end
  endtask

  task automatic test_mid_reset();
    set_ex(1'b1, OPCODE_JAL, 32'h10, 1'b0, 32'h40, 1'b0, 32'h14);
    next_cycle();
    steer(32'h10);
    tests++; if (pred_taken !== 1'b1 || pred_target !== 32'h40) begin failed++; $display("FAIL jal_trained: got pt=%b tgt=%h want 1/00000040", pred_taken, pred_target); end
    reset = 1'b1;
    set_ex(1'b1, OPCODE_JAL, 32'h20, 1'b0, 32'h80, 1'b0, 32'h24);
    #1;
    tests++; if (flush !== 1'b0 || pc_input_sel !== PC_INPUT_PC_PLUS_4) begin failed++; $display("FAIL midreset_fl: got fl=%b sel=%0d want 0/0", flush, pc_input_sel); end
    next_cycle();
    reset = 1'b0;
    #1;
    tests++; if (pc !== 32'h0) begin failed++; $display("FAIL midreset_pc: got %h want 00000000", pc); end
    steer(32'h10);
    tests++; if (pred_taken !== 1'b0 || pred_target !== 32'h14) begin failed++; $display("FAIL midreset_10: got pt=%b tgt=%h want 0/00000014", pred_taken, pred_target); end
    steer(32'h20);
    tests++; if (pred_taken !== 1'b0 || pred_target !== 32'h24) begin failed++; $display("FAIL midreset_20: got pt=%b tgt=%h want 0/00000024", pred_taken, pred_target); end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    idle_ex();
    test_reset();
    test_branch_train();
    test_branch_untrain();
    test_jalr();
    test_stall();
    test_alias();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, tests=%0d failed=%0d", tests, failed);
    $fatal(1);
  end

endmodule
